// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 size codes, FSM
// state encoding and the fixed data width.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/lsu_rmw_if.sv
// Bundle of the core request/response handshake and the data memory port.
// slave  : the load/store unit side.
// master : the core + memory side.
interface lsu_rmw_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational alignment helper for the load/store unit.
//   chk_*     : request being offered; chk_err flags misaligned/illegal ones.
//   funct3,
//   addr_lo   : registered request fields.
//   old_word  : word read from memory.
//   wdata     : store data (low byte/half used for SB/SH).
//   load_data : extracted and sign/zero-extended load result.
//   merged    : word to write back (whole wdata for SW).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        chk_funct3,
  input  logic              chk_store,
  input  logic [1:0]        chk_addr_lo,
  output logic              chk_err,
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    unique case (chk_funct3)
      F3_B, F3_BU: chk_err = chk_store & chk_funct3[2];
      F3_H, F3_HU: chk_err = (chk_store & chk_funct3[2]) | chk_addr_lo[0];
      F3_W:        chk_err = (chk_addr_lo != 2'b00);
      default:     chk_err = 1'b1;
    endcase
  end

  always_comb begin
    sel_byte = old_word[{addr_lo, 3'b000} +: 8];
    sel_half = old_word[{addr_lo[1], 4'b0000} +: 16];
    unique case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_data = {24'b0, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_data = {16'b0, sel_half};
      default: load_data = old_word;
    endcase
  end

  always_comb begin
    merged = old_word;
    unique case (funct3)
      F3_B:    merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H:    merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit between execute and a word-addressed data memory.
// Sub-word stores are done as read-modify-write; misaligned or illegal
// requests get an error response without touching memory.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : request/response handshake and data memory port (slave side)
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input logic      clk,
  input logic      rst_n,
  lsu_rmw_if.slave bus
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          funct3_q;
  logic                store_q;
  logic                err_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   word_q;

  logic                chk_err;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   merged;
  logic                accept;

  lsu_align u_align (
    .chk_funct3  (bus.req_funct3),
    .chk_store   (bus.req_store),
    .chk_addr_lo (bus.req_addr[1:0]),
    .chk_err     (chk_err),
    .funct3      (funct3_q),
    .addr_lo     (addr_q[1:0]),
    .old_word    (word_q),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merged      (merged)
  );

  assign accept = (state_q == StIdle) && bus.req_valid;

  // All memory-side outputs depend only on state and registered fields.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (chk_err) begin
            state_d = StResp;
          end else if (bus.req_store && (bus.req_funct3 == F3_W)) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        bus.mem_read = 1'b1;
        bus.mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        state_d      = store_q ? StWrite : StResp;
      end
      StWrite: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        bus.mem_wdata = merged;
        state_d       = StResp;
      end
      StResp: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = err_q;
        bus.rsp_rdata = (store_q || err_q) ? '0 : load_data;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      word_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= bus.req_addr;
        funct3_q <= bus.req_funct3;
        store_q  <= bus.req_store;
        err_q    <= chk_err;
        wdata_q  <= bus.req_wdata;
      end
      if (state_q == StRead) begin
        word_q <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a 128-word behavioural data memory.
module tb_lsu_rmw;

  logic clk;
  logic rst_n;

  lsu_rmw_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  lsu_rmw #(.ADDR_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model; preloads go through the same write port.
  logic [31:0] mem [0:127];
  logic        pre_we;
  logic [6:0]  pre_idx;
  logic [31:0] pre_data;

  assign bus.mem_rdata = mem[bus.mem_addr[8:2]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (bus.mem_write) mem[bus.mem_addr[8:2]] <= bus.mem_wdata;
  end

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic poke(input logic [8:0] addr, input logic [31:0] data);
    pre_idx  = addr[8:2];
    pre_data = data;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  // Issue one request and check every cycle until back in IDLE.
  // keep=1 leaves req_valid high while busy (must be ignored).
  task automatic run(input string tag, input logic store, input logic [2:0] f3,
                     input logic [8:0] addr, input logic [31:0] wdata, input bit keep,
                     input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                     input bit exp_err);
    int lat;
    int rd_c;
    int wr_c;
    if (exp_err) begin
      lat = 1; rd_c = 0; wr_c = 0;
    end else if (!store) begin
      lat = 2; rd_c = 1; wr_c = 0;
    end else if (f3 == 3'b010) begin
      lat = 2; rd_c = 0; wr_c = 1;
    end else begin
      lat = 3; rd_c = 1; wr_c = 2;
    end
    bus.req_valid  = 1'b1;
    bus.req_store  = store;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    if (!keep) bus.req_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      check({tag, "/rsp_valid"}, {31'b0, bus.rsp_valid}, {31'b0, k == lat});
      check({tag, "/req_ready"}, {31'b0, bus.req_ready}, 32'd0);
      check({tag, "/mem_read"}, {31'b0, bus.mem_read}, {31'b0, k == rd_c});
      check({tag, "/mem_write"}, {31'b0, bus.mem_write}, {31'b0, k == wr_c});
      if (k == rd_c || k == wr_c)
        check({tag, "/mem_addr"}, {23'b0, bus.mem_addr}, {23'b0, addr & 9'h1FC});
      if (k == wr_c)
        check({tag, "/mem_wdata"}, bus.mem_wdata, exp_wdata);
      if (k == lat) begin
        check({tag, "/rsp_rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, "/rsp_err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});
      end else begin
        check({tag, "/rsp_rdata_idle"}, bus.rsp_rdata, 32'd0);
      end
      @(posedge clk); #1;
    end
    check({tag, "/ready_after"}, {31'b0, bus.req_ready}, 32'd1);
    check({tag, "/rsp_after"}, {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    check({tag, "/rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    check({tag, "/rsp_err"}, {31'b0, bus.rsp_err}, 32'd0);
    check({tag, "/rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "/mem_read"}, {31'b0, bus.mem_read}, 32'd0);
    check({tag, "/mem_write"}, {31'b0, bus.mem_write}, 32'd0);
    check({tag, "/mem_addr"}, {23'b0, bus.mem_addr}, 32'd0);
    check({tag, "/mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  initial begin
    n_vec          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    pre_we         = 1'b0;
    pre_idx        = '0;
    pre_data       = '0;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    #1;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte loads with sign/zero extension.
    poke(9'h010, 32'h8899AABB);
    run("lb13",  1'b0, 3'b000, 9'h013, 32'h0, 1'b0, 32'h0, 32'hFFFFFF88, 1'b0);
    run("lbu13", 1'b0, 3'b100, 9'h013, 32'h0, 1'b0, 32'h0, 32'h00000088, 1'b0);
    run("lb10",  1'b0, 3'b000, 9'h010, 32'h0, 1'b0, 32'h0, 32'hFFFFFFBB, 1'b0);

    // SB read-modify-write, then read back.
    poke(9'h020, 32'h12345678);
    run("sb21", 1'b1, 3'b000, 9'h021, 32'hAAAAAACD, 1'b0, 32'h1234CD78, 32'h0, 1'b0);
    run("lw20", 1'b0, 3'b010, 9'h020, 32'h0, 1'b0, 32'h0, 32'h1234CD78, 1'b0);

    // SH into upper half, then halfword loads.
    poke(9'h040, 32'hFFFF0000);
    run("sh42",  1'b1, 3'b001, 9'h042, 32'h5555BEEF, 1'b0, 32'hBEEF0000, 32'h0, 1'b0);
    run("lh42",  1'b0, 3'b001, 9'h042, 32'h0, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0);
    run("lhu42", 1'b0, 3'b101, 9'h042, 32'h0, 1'b0, 32'h0, 32'h0000BEEF, 1'b0);
    run("lh40",  1'b0, 3'b001, 9'h040, 32'h0, 1'b0, 32'h0, 32'h00000000, 1'b0);

    // Misaligned / illegal requests.
    run("lw06",   1'b0, 3'b010, 9'h006, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    run("sh05",   1'b1, 3'b001, 9'h005, 32'h1234, 1'b0, 32'h0, 32'h0, 1'b1);
    run("sf3_4",  1'b1, 3'b100, 9'h008, 32'h77, 1'b0, 32'h0, 32'h0, 1'b1);
    run("lf3_3",  1'b0, 3'b011, 9'h000, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    run("lh41",   1'b0, 3'b001, 9'h041, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);

    // SW with req_valid held high across two back-to-back requests.
    run("sw7c_a", 1'b1, 3'b010, 9'h07C, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0);
    run("sw7c_b", 1'b1, 3'b010, 9'h07C, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    run("lw7c",   1'b0, 3'b010, 9'h07C, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    run("lb7e",   1'b0, 3'b000, 9'h07E, 32'h0, 1'b0, 32'h0, 32'hFFFFFFAD, 1'b0);

    // Reset asserted while an SB is in READ.
    poke(9'h030, 32'hA5A5A5A5);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 9'h031;
    bus.req_wdata  = 32'h0000003C;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    check("rst/in_read", {31'b0, bus.mem_read}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst/async");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst/held_write", {31'b0, bus.mem_write}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst/post_write", {31'b0, bus.mem_write}, 32'd0);
    end
    check_reset_outputs("rst/after");
    check("rst/word", mem[12], 32'hA5A5A5A5);
    run("lw30", 1'b0, 3'b010, 9'h030, 32'h0, 1'b0, 32'h0, 32'hA5A5A5A5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_rmw.md
Name: lsu_rmw

Overview:
- Load/store unit between the execute stage and the word-addressed data memory.
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on the data memory port.
- Sub-word stores use read-modify-write, because the data memory writes only whole words.
- Load data is sign- or zero-extended; misaligned or illegal requests get an error response with no memory access.

Parameters:
ADDR_W, 9, byte-address width. Word index is addr[ADDR_W-1:2].
DATA_W, 32, data width. Fixed at 32; other values unsupported.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  core presents a request
req_ready  output  1  unit can accept a request; high only in IDLE
req_store  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (size/sign)
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data; the low byte/half is used for SB/SH
rsp_valid  output  1  one-cycle response pulse
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  request was misaligned or illegal; valid with rsp_valid
mem_read  output  1  data memory read enable
mem_write  output  1  data memory write enable
mem_addr  output  ADDR_W  data memory address, always word-aligned (low 2 bits 0)
mem_wdata  output  32  data memory write word
mem_rdata  input  32  data memory read word, combinational from mem_addr/mem_read

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset state: FSM in IDLE, req_ready=1, and all of these are 0: rsp_valid, rsp_err, rsp_rdata, mem_read, mem_write, mem_addr, mem_wdata, internal regs.
- FSM states: IDLE, READ, WRITE, RESP.
- Accept: on the clk edge where req_valid & req_ready, register addr, funct3, store flag, wdata, and the error flag.
- Error flag is set when any of these holds:
  - funct3 is 011, 110 or 111;
  - a store has funct3[2]=1;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0.
- Transitions from IDLE after accept:
  - error -> RESP;
  - load, SB or SH -> READ;
  - SW -> WRITE.
- READ (1 cycle):
  - mem_read=1, mem_addr={addr[ADDR_W-1:2],2'b00}; mem_rdata is captured into a word register at the clk edge.
  - Load -> RESP. SB/SH -> WRITE.
- WRITE (1 cycle):
  - mem_write=1, mem_addr as in READ, mem_wdata = merged word (or req_wdata for SW).
  - SB replaces byte addr[1:0]; SH replaces half addr[1]; all other bytes come from the captured word.
  - WRITE -> RESP.
- RESP (1 cycle): rsp_valid=1, then -> IDLE. rsp_rdata and rsp_err are valid only while rsp_valid=1 and are 0 otherwise.
- Load extraction, on the captured word:
  - LB/LBU take byte addr[1:0]; LH/LHU take half addr[1]; LW takes the full word.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- mem_read, mem_write and mem_addr are decoded from state and registered fields only, never from req_* inputs. mem_read and mem_write are never high together.
- Latency, counted from the accept edge T:
  - misaligned/illegal: rsp_valid in cycle T+1;
  - load and SW: READ or WRITE in T+1, RESP in T+2;
  - SB/SH: READ T+1, WRITE T+2, RESP T+3.
- Back-to-back: a new request can be accepted on the edge that leaves RESP (req_ready=1 again in IDLE). Throughput is therefore 1 request per 3 cycles (load/SW) or 4 cycles (SB/SH).
- req_valid is ignored while not in IDLE; the core stalls on !req_ready.
- Reset mid-operation: FSM goes to IDLE immediately and mem_write drops asynchronously.
  - Reset in READ: memory is untouched.
  - Reset in WRITE: the full-word write may or may not have landed; there is never a partially merged word.
- Address wrap: none. Addresses are mod 2^ADDR_W by width.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101;
  - FSM state encoding (2 bits);
  - DATA_W constant.
- One natural sub-module, lsu_align: purely combinational. Provides the error check, load extract/extend (word, funct3, addr[1:0] -> 32b), and store merge (old word, wdata, funct3, addr[1:0] -> 32b).
- lsu_rmw holds the FSM and registers.

Test Plan:
- Memory word 0x10 = 0x8899AABB; LB at 0x13 -> rsp_rdata=0xFFFFFF88, rsp_err=0, rsp_valid at T+2; LBU at 0x13 -> 0x00000088.
- Memory word 0x20 = 0x12345678; SB 0xCD at 0x21 -> READ at T+1, WRITE at T+2 with mem_wdata=0x1234CD78, rsp_valid at T+3; a following LW at 0x20 returns 0x1234CD78.
- Memory word 0x40 = 0xFFFF0000; SH 0xBEEF at 0x42 -> mem_wdata=0xBEEF0000; LH at 0x42 -> 0xFFFFBEEF; LHU -> 0x0000BEEF.
- LW at 0x06 and SH at 0x05 -> rsp_err=1 at T+1, rsp_rdata=0; mem_read and mem_write stay 0 throughout. Store with funct3=100 -> rsp_err=1.
- SW 0xDEADBEEF at 0x7C with req_valid held high -> WRITE at T+1, RESP at T+2; next request accepted on the edge leaving RESP. req_ready=0 during READ/WRITE/RESP, and requests offered then are ignored.
- SB issued, rst_n pulsed low during READ -> mem_write never asserts, target word unchanged, all outputs at reset values, req_ready=1 after release.
